// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes, MDU funct3 encodings, MDU FSM states and the base decode
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_BEQ  = 4'h4;
  localparam logic [3:0] ALU_SLT  = 4'h5;
  localparam logic [3:0] ALU_XOR  = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [3:0] ALU_SLTU = 4'hA;
  localparam logic [3:0] ALU_BNE  = 4'hB;
  localparam logic [3:0] ALU_BGE  = 4'hC;
  localparam logic [3:0] ALU_BGEU = 4'hD;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_f3_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [3:0] alu_decode(input logic [1:0] sel, input logic [2:0] f3,
                                            input logic op, input logic f7_5);
    logic [3:0] code;
    code = ALU_ADD;
    case (sel)
      2'b01: begin
        case (f3)
          3'b000:  code = ALU_BEQ;
          3'b001:  code = ALU_BNE;
          3'b100:  code = ALU_SLT;
          3'b101:  code = ALU_BGE;
          3'b110:  code = ALU_SLTU;
          3'b111:  code = ALU_BGEU;
          default: code = ALU_SUB;
        endcase
      end
      2'b10: begin
        case (f3)
          3'b000:  code = (op && f7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b010:  code = ALU_SLT;
          3'b011:  code = ALU_SLTU;
          3'b100:  code = ALU_XOR;
          3'b101:  code = f7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  code = ALU_OR;
          default: code = ALU_AND;
        endcase
      end
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M unit: radix-2 shift-add multiply / restoring divide on one shared register
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      f3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result,
  output logic            done
);

  localparam int CW = $clog2(XLEN);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic [2:0]        fn;
  logic              neg;

  logic              is_div, a_sgn, b_sgn, a_neg, b_neg, neg_in, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, fast_res, div_val, div_fix, final_res;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, prod;

  // Operands are reduced to magnitudes; one sign flag fixes up the result at the end.
  always_comb begin
    is_div   = f3[2];
    a_sgn    = is_div ? ~f3[0] : (f3[1:0] != 2'b11);
    b_sgn    = is_div ? ~f3[0] : ~f3[1];
    a_neg    = a_sgn & rs1[XLEN-1];
    b_neg    = b_sgn & rs2[XLEN-1];
    a_mag    = a_neg ? -rs1 : rs1;
    b_mag    = b_neg ? -rs2 : rs2;
    neg_in   = (is_div && f3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (rs2 == '0);
    div_ovf  = is_div && !f3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
    if (div_zero) fast_res = f3[1] ? rs1 : '1;
    else          fast_res = f3[1] ? '0 : rs1;
  end

  // acc holds {hi, lo}: product/multiplier for mul, remainder/quotient for div.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_nxt   = {mul_sum, acc[XLEN-1:1]};
    rem_sh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff      = rem_sh - {1'b0, opb};
    div_nxt   = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_nxt   = fn[2] ? div_nxt : mul_nxt;
    prod      = neg ? -acc_nxt : acc_nxt;
    div_val   = fn[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    div_fix   = neg ? -div_val : div_val;
    if (fn[2])               final_res = div_fix;
    else if (fn[1:0] == 2'b00) final_res = prod[XLEN-1:0];
    else                     final_res = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      fn     <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            fn  <= f3;
            neg <= neg_in;
            opb <= b_mag;
            acc <= {{XLEN{1'b0}}, a_mag};
            cnt <= CW'(XLEN - 1);
            if (div_zero || div_ovf) begin
              result <= fast_res;
              state  <= ST_DONE;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result <= final_res;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign done = (state == ST_DONE) && !flush;

endmodule

// File: rtl/alu_ctrl_mdu.sv
// rtl/alu_ctrl_mdu.sv - EX-stage ALU decoder with optional iterative RV32M unit and stall handshake
module alu_ctrl_mdu
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int M_EXT    = 1,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  input  logic                flush_i,
  input  logic [1:0]          sel,
  input  logic [2:0]          f3,
  input  logic                op,
  input  logic                f7_5,
  input  logic                f7_0,
  input  logic [XLEN-1:0]     rs1_i,
  input  logic [XLEN-1:0]     rs2_i,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                md_sel,
  output logic [XLEN-1:0]     md_result,
  output logic                md_done,
  output logic                stall_o
);

  logic [3:0] code;
  logic       mdu_op;

  assign code    = alu_decode(sel, f3, op, f7_5);
  assign alu_op  = ALU_OP_W'(code);
  assign mdu_op  = (M_EXT != 0) && valid_i && (sel == 2'b10) && op && f7_0;
  assign md_sel  = mdu_op;
  assign stall_o = mdu_op && !md_done && !flush_i;

  if (M_EXT != 0) begin : g_mdu
    mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mdu_op),
      .flush  (flush_i),
      .f3     (f3),
      .rs1    (rs1_i),
      .rs2    (rs2_i),
      .result (md_result),
      .done   (md_done)
    );
  end else begin : g_no_mdu
    logic unused_mdu;
    assign unused_mdu = ^{clk, rst_n, valid_i, f7_0, rs1_i, rs2_i};
    assign md_result  = '0;
    assign md_done    = 1'b0;
  end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb/tb_alu_ctrl_mdu.sv - randomized self-checking bench for alu_ctrl_mdu against an arithmetic reference
module tb_alu_ctrl_mdu;
  import alu_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid_i = 1'b0, valid0 = 1'b0, flush_i = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [2:0]  f3 = 3'b000;
  logic        op = 1'b0, f7_5 = 1'b0, f7_0 = 1'b0;
  logic [31:0] rs1_i = '0, rs2_i = '0;

  logic [3:0]  alu_op, alu_op0;
  logic        md_sel, md_done, stall_o, md_sel0, md_done0, stall_o0;
  logic [31:0] md_result, md_result0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  alu_ctrl_mdu #(.XLEN(32), .M_EXT(1), .ALU_OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i), .sel(sel), .f3(f3),
    .op(op), .f7_5(f7_5), .f7_0(f7_0), .rs1_i(rs1_i), .rs2_i(rs2_i), .alu_op(alu_op),
    .md_sel(md_sel), .md_result(md_result), .md_done(md_done), .stall_o(stall_o)
  );

  alu_ctrl_mdu #(.XLEN(32), .M_EXT(0), .ALU_OP_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid0), .flush_i(flush_i), .sel(sel), .f3(f3),
    .op(op), .f7_5(f7_5), .f7_0(f7_0), .rs1_i(rs1_i), .rs2_i(rs2_i), .alu_op(alu_op0),
    .md_sel(md_sel0), .md_result(md_result0), .md_done(md_done0), .stall_o(stall_o0)
  );

  assert property (@(posedge clk) disable iff (!rst_n || flush_i)
                   (dut.g_mdu.u_mdu.state == ST_RUN) |-> valid_i)
    else $error("valid_i dropped while the MDU was running");

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [1:0] s, input logic [2:0] f, input logic o,
                                         input logic f75);
    logic [3:0] br_tab [8];
    logic [3:0] ar_tab [8];
    br_tab = '{4'h4, 4'hB, 4'h1, 4'h1, 4'h5, 4'hC, 4'hA, 4'hD};
    ar_tab = '{4'h0, 4'h7, 4'h5, 4'hA, 4'h6, 4'h8, 4'h3, 4'h2};
    if (s == 2'b01) return br_tab[f];
    if (s != 2'b10) return 4'h0;
    if (f == 3'd0 && o && f75) return 4'h1;
    if (f == 3'd5 && f75) return 4'h9;
    return ar_tab[f];
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic run_mdu(input string tag, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    int lat, stalls, exp_lat;
    logic [31:0] got;
    exp_lat = (fn[2] && (b == 0 || (!fn[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
    @(negedge clk);
    valid_i = 1'b1; sel = 2'b10; op = 1'b1; f7_5 = 1'b0; f7_0 = 1'b1; f3 = fn; rs1_i = a; rs2_i = b;
    #1;
    check($sformatf("%s md_sel", tag), md_sel, 1);
    lat = -1; stalls = 0; got = '0;
    for (int k = 0; k < 40; k++) begin
      if (md_done) begin
        lat = k; got = md_result;
        break;
      end
      if (stall_o) stalls++;
      @(negedge clk); #1;
    end
    check($sformatf("%s latency", tag), 64'(lat), 64'(exp_lat));
    check($sformatf("%s stalls", tag), 64'(stalls), 64'(exp_lat));
    check($sformatf("%s result f3=%0d a=%h b=%h", tag, fn, a, b), got, ref_md(fn, a, b));
    @(posedge clk); #1;
    valid_i = 1'b0; f7_0 = 1'b0;
  endtask

  task automatic set_dec(input logic [1:0] s, input logic [2:0] f, input logic o, input logic f75);
    @(negedge clk);
    valid_i = 1'b0; sel = s; f3 = f; op = o; f7_5 = f75; f7_0 = 1'b0;
    #1;
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    check("reset md_done", md_done, 0);
    check("reset md_result", md_result, 0);
    check("reset md_sel", md_sel, 0);
    check("reset stall", stall_o, 0);
    rst_n = 1'b1;

    set_dec(2'b10, 3'b000, 1'b1, 1'b1); check("dec sub", alu_op, 4'h1);
    set_dec(2'b10, 3'b101, 1'b1, 1'b1); check("dec sra", alu_op, 4'h9);
    set_dec(2'b01, 3'b001, 1'b0, 1'b0); check("dec bne", alu_op, 4'hB);
    set_dec(2'b00, 3'b111, 1'b1, 1'b1); check("dec ldst", alu_op, 4'h0);

    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      sel = 2'($urandom); f3 = 3'($urandom); op = 1'($urandom); f7_5 = 1'($urandom);
      f7_0 = 1'($urandom); valid_i = 1'b0; valid0 = 1'($urandom);
      #1;
      check($sformatf("rand dec sel=%b f3=%b", sel, f3), alu_op, ref_alu(sel, f3, op, f7_5));
      check("rand dec m0", alu_op0, ref_alu(sel, f3, op, f7_5));
      check("rand dec stall", {stall_o, md_sel, stall_o0, md_sel0}, 0);
    end
    valid0 = 1'b0;

    run_mdu("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul value", md_result, 32'hFFFF_FFEB);
    run_mdu("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mdu("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mdu("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_mdu("divu zero", 3'd5, 32'h1234_5678, 32'h0);
    run_mdu("rem zero", 3'd6, 32'd5, 32'h0);
    run_mdu("div neg", 3'd4, 32'hFFFF_FFF9, 32'd2);
    run_mdu("rem neg", 3'd6, 32'hFFFF_FFF9, 32'd2);
    run_mdu("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) run_mdu("rand", 3'($urandom), pick(), pick());

    @(negedge clk);
    valid_i = 1'b1; sel = 2'b10; op = 1'b1; f7_0 = 1'b1; f3 = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush stall forced", stall_o, 0);
    @(posedge clk); #1;
    flush_i = 1'b0; valid_i = 1'b0; f7_0 = 1'b0;
    @(negedge clk); #1;
    check("flush stall next", stall_o, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (md_done) seen++;
      @(negedge clk);
    end
    check("flush no done", 64'(seen), 0);
    run_mdu("after flush", 3'd0, 32'd7, 32'hFFFF_FFFD);

    @(negedge clk);
    valid_i = 1'b1; sel = 2'b10; op = 1'b1; f7_0 = 1'b1; f3 = 3'd0; rs1_i = 32'd3; rs2_i = 32'd5;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun reset result", md_result, 0);
    check("midrun reset done", md_done, 0);
    valid_i = 1'b0; f7_0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (md_done) seen++;
      @(negedge clk);
    end
    check("midrun reset no done", 64'(seen), 0);
    run_mdu("after reset", 3'd1, 32'h8000_0000, 32'h8000_0000);

    @(negedge clk);
    valid_i = 1'b0; valid0 = 1'b1; sel = 2'b10; f3 = 3'b000; op = 1'b1; f7_5 = 1'b0; f7_0 = 1'b1;
    #1;
    check("m0 add alu_op", alu_op0, 4'h0);
    check("m0 stall", stall_o0, 0);
    check("m0 md_sel", md_sel0, 0);
    @(negedge clk); #1;
    check("m0 no done", md_done0, 0);
    valid0 = 1'b0; f7_0 = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
